// File: rtl/dual_port_memory_if.sv
// ============================================================================
// Module      : dual_port_memory_if
// Description : Write/read port bundle for dual_port_memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dual_port_memory_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
);
    localparam int NBYTE = DWIDTH / 8;

    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic [NBYTE-1:0]  wr_be;
    logic              rd_en;
    logic [AWIDTH-1:0] rd_addr;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/dual_port_memory.sv
// ============================================================================
// Module      : dual_port_memory
// Description : Simple-dual-port RAM with byte-lane writes, registered read
//               and a post-reset clear sequencer. Define MEM_BYPASS_EN for
//               write-to-read forwarding on same-address collisions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_port_memory #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dual_port_memory_if.slave  bus
);
    localparam int NBYTE = DWIDTH / 8;
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    state_t            state_q;
    logic [AWIDTH-1:0] cnt_q;
    logic [AWIDTH-1:0] cnt_d;
    logic              busy_q;
    logic              rd_valid_q;
    logic [DWIDTH-1:0] rd_data_q;

    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [NBYTE-1:0]  mem_wbe;
    logic [DWIDTH-1:0] rd_word;

    // The clear sequencer takes over the write port while busy.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        mem_we    = bus.wr_en;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        mem_wbe   = bus.wr_be;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (mem_wbe[b]) begin
                    mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef MEM_BYPASS_EN
    logic fwd_hit;
    assign fwd_hit = bus.wr_en && (bus.wr_addr == bus.rd_addr);

    for (genvar b = 0; b < NBYTE; b++) begin : g_byp
        assign rd_word[8*b +: 8] = (fwd_hit && bus.wr_be[b]) ? bus.wr_data[8*b +: 8]
                                                             : mem_q[bus.rd_addr][8*b +: 8];
    end
`else
    assign rd_word = mem_q[bus.rd_addr];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    rd_valid_q <= 1'b0;
                    cnt_q      <= cnt_d;
                    if (cnt_q == {AWIDTH{1'b1}}) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READY: begin
                    rd_valid_q <= bus.rd_en;
                    if (bus.rd_en) begin
                        rd_data_q <= rd_word;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_memory.sv
// ============================================================================
// Module      : tb_dual_port_memory
// Description : Scoreboard bench for dual_port_memory against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_port_memory;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;

    dual_port_memory_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    dual_port_memory #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd;
    int            n_cmp;
    int            n_err;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Monitor: pops on each valid read, otherwise requires rd_data to hold.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
            check("rst_rd_data", bus.rd_data, 32'd0);
            last_rd = '0;
        end else if (bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rd_valid: got data 0x%08h required no valid at %0t",
                         bus.rd_data, $time);
            end else begin
                last_rd = exp_q.pop_front();
                check("rd_data", bus.rd_data, last_rd);
            end
        end else begin
            check("rd_hold", bus.rd_data, last_rd);
        end
    end

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
    endtask

    // One READY-state cycle; expected read value comes from the model unless forced.
    task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra,
                      input bit use_force = 1'b0, input logic [DW-1:0] force_exp = '0);
        logic [DW-1:0] e;
        @(posedge clk);
        #2;
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_be = be;
        bus.rd_en = re; bus.rd_addr = ra;
        if (re) begin
            e = ref_mem[ra];
`ifdef MEM_BYPASS_EN
            if (we && wa == ra) e = merge(e, wd, be);
`endif
            exp_q.push_back(use_force ? force_exp : e);
        end
        if (we) ref_mem[wa] = merge(ref_mem[wa], wd, be);
    endtask

    task automatic assert_rst();
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_busy_now", {31'd0, bus.busy}, 32'd1);
        check("rst_valid_now", {31'd0, bus.rd_valid}, 32'd0);
    endtask

    // Releases reset, pokes random requests while busy, and counts busy cycles.
    task automatic release_and_count();
        int cnt;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cnt++;
            bus.wr_en = 1'($urandom); bus.wr_addr = AW'($urandom); bus.wr_data = $urandom;
            bus.wr_be = NB'($urandom); bus.rd_en = 1'($urandom); bus.rd_addr = AW'($urandom);
        end
        idle_inputs();
        check("busy_cycles", cnt, DEPTH);
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < DEPTH; a++) op(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1, 32'd0);
        op(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_rd = '0;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd1);

        release_and_count();
        read_all_zero();

        // Byte lanes.
        op(1'b1, 5'd3, 32'hAABBCCDD, 4'b1111, 1'b0, '0);
        op(1'b1, 5'd3, 32'h11223344, 4'b0101, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b1, 32'hAA22CC44);

        // Same-address collision.
        op(1'b1, 5'd7, 32'h0, 4'b1111, 1'b0, '0);
`ifdef MEM_BYPASS_EN
        op(1'b1, 5'd7, 32'hDEADBEEF, 4'b0011, 1'b1, 5'd7, 1'b1, 32'h0000BEEF);
`else
        op(1'b1, 5'd7, 32'hDEADBEEF, 4'b0011, 1'b1, 5'd7, 1'b1, 32'h00000000);
`endif
        op(1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b1, 32'h0000BEEF);

        // Streaming across the top of the address space.
        op(1'b1, 5'd30, 32'h30303030, 4'hF, 1'b0, '0);
        op(1'b1, 5'd31, 32'h31313131, 4'hF, 1'b0, '0);
        op(1'b1, 5'd0,  32'h00000A0A, 4'hF, 1'b0, '0);
        op(1'b1, 5'd1,  32'h01010101, 4'hF, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 5'd30, 1'b1, 32'h30303030);
        op(1'b0, '0, '0, '0, 1'b1, 5'd31, 1'b1, 32'h31313131);
        op(1'b0, '0, '0, '0, 1'b1, 5'd0,  1'b1, 32'h00000A0A);
        op(1'b0, '0, '0, '0, 1'b1, 5'd1,  1'b1, 32'h01010101);
        repeat (3) op(1'b0, '0, '0, '0, 1'b0, '0);

        // Write n while reading n-1.
        op(1'b1, 5'd0, $urandom, 4'hF, 1'b0, '0);
        for (int n = 1; n < DEPTH; n++) op(1'b1, AW'(n), $urandom, 4'hF, 1'b1, AW'(n - 1));

        // Random traffic, narrow address range to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            op(1'($urandom), AW'($urandom_range(0, 7)), $urandom, NB'($urandom),
               1'($urandom), AW'($urandom_range(0, 7)));
        end
        op(1'b0, '0, '0, '0, 1'b0, '0);

        // Reset mid-clear and mid-operation.
        assert_rst();
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        assert_rst();
        release_and_count();
        read_all_zero();
        op(1'b1, 5'd9, 32'hCAFEF00D, 4'hF, 1'b1, 5'd9);
        assert_rst();
        release_and_count();
        read_all_zero();

        repeat (3) op(1'b0, '0, '0, '0, 1'b0, '0);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dual_port_memory.md
# dual_port_memory

- Parametrised simple-dual-port RAM: one write port, one read port.
- Adds byte-lane write enables and a registered read with a valid strobe.
- A hardware clear sequencer zeroes every word after reset.
- Sits between the datapath and instruction/data stores wherever simultaneous read and write are required.

## Interface
Parameters:
- AWIDTH, 5, address width; depth = 2**AWIDTH words
- DWIDTH, 32, data width; must be a multiple of 8; NBYTE = DWIDTH/8 lanes

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- wr_en  input  1  write request
- wr_addr  input  AWIDTH  write address
- wr_data  input  DWIDTH  write data
- wr_be  input  NBYTE  byte-lane enables; bit i covers wr_data[8i+7:8i]
- rd_en  input  1  read request
- rd_addr  input  AWIDTH  read address
- rd_data  output  DWIDTH  registered read data
- rd_valid  output  1  rd_data updated this cycle
- busy  output  1  clear in progress; requests ignored

## Operation
- FSM states: CLEAR, READY.
- Reset asserted:
  - state=CLEAR, clear counter=0.
  - busy=1, rd_valid=0, rd_data=0.
- CLEAR state:
  - Each cycle writes all-zero to mem[counter], then counter increments.
  - After the cycle that writes address 2**AWIDTH-1, the FSM moves to READY and busy=0.
  - wr_en and rd_en are ignored: no memory update, rd_valid=0.
- READY, write:
  - wr_en=1 updates byte lanes of mem[wr_addr] whose wr_be bit is 1; other lanes are unchanged.
  - wr_be=0 is a no-op.
- READY, read:
  - rd_en=1 samples rd_addr; rd_data takes mem[rd_addr] on the same edge, and rd_valid=1 for that cycle.
  - rd_en=0: rd_valid=0 and rd_data holds its last value.
- Reads and writes to different addresses are fully independent; both may occur every cycle.
- Read-during-write to the same address: result is set by MEM_BYPASS_EN (see Configuration).
- Addresses are exact, with no wrap logic; rd_addr=2**AWIDTH-1 followed by 0 needs no special handling.
- Reset mid-CLEAR or mid-operation aborts immediately. It restarts the clear from address 0 and drops any pending rd_valid.

## Timing
- Write latency: data is visible to a read issued on the next edge (1 cycle).
- Read latency: 1 cycle from rd_en sample to rd_valid/rd_data.
- Throughput: 1 read + 1 write per cycle in READY.
- Clear duration: 2**AWIDTH cycles after rst deasserts. busy falls on the edge after the last clear write, i.e. 32 cycles for AWIDTH=5.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: MEM_BYPASS_EN.
- Defined: same-address read-during-write returns new data.
  - Each lane with wr_be=1 comes from wr_data; other lanes come from stored data.
  - Adds a forwarding mux; rd_data latency is unchanged.
- Undefined: same-address read-during-write returns old stored data (read-first). No forwarding logic is compiled in.

## Test plan
- Clear check: release rst, count busy cycles.
  - Required: busy=1 for exactly 32 cycles (AWIDTH=5).
  - Then reading addresses 0..31 returns 0x00000000 with rd_valid=1 each cycle after rd_en.
- Byte enables: write 0xAABBCCDD, be=4'b1111, at addr 3; then write 0x11223344, be=4'b0101, at addr 3; then read addr 3.
  - Required: rd_data=0xAA22CC44.
- Collision: mem[7]=0x0; same cycle wr_en at addr 7 with data 0xDEADBEEF, be=4'b0011, and rd_en at addr 7.
  - With MEM_BYPASS_EN: rd_data=0x0000BEEF.
  - Without it: rd_data=0x00000000.
  - Next read of addr 7 returns 0x0000BEEF in both builds.
- Streaming: rd_en held high with rd_addr 30, 31, 0, 1 on consecutive cycles after writing distinct values there.
  - Required: rd_valid=1 four consecutive cycles with matching data, then rd_valid=0 and rd_data held.
- Reset mid-clear: assert rst at clear cycle 10.
  - Required: busy stays 1 and rd_valid=0 immediately.
  - After release, the clear restarts and busy lasts a full 32 cycles.
  - wr_en/rd_en pulsed during busy cause no write and no rd_valid.
- Concurrent independent ports: each cycle write addr n and read addr n-1 for n=1..31.
  - Required: every read returns the value written one cycle earlier.
